// File: rtl/truth_table_tx.sv
// Collects one result bit per swept input vector into a bitmap and, on sweep end,
// sends it as an 8N1 UART frame: A5, count, bitmap bytes, XOR checksum.
module truth_table_tx #(
   parameter int unsigned BITS         = 3,
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sample_valid,
   input  logic [BITS-1:0] sample_vec,
   input  logic            sample_bit,
   input  logic            sweep_done,
   output logic            tx,
   output logic            busy,
   output logic            any_high,
   output logic            overrun
);

   localparam int unsigned N       = 1 << BITS;
   localparam int unsigned NBYTES  = (N + 7) / 8;
   localparam int unsigned NFRAME  = NBYTES + 3;
   localparam int unsigned BAUD_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W   = $clog2(NFRAME + 1);
   localparam logic [7:0]  HEADER  = 8'hA5;

   typedef enum logic [2:0] {
      S_COLLECT = 3'd0,
      S_LOAD    = 3'd1,
      S_START   = 3'd2,
      S_DATA    = 3'd3,
      S_STOP    = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [BAUD_W-1:0]     r_baud;
   logic [2:0]            r_bit;
   logic [IDX_W-1:0]      r_idx;
   logic [7:0]            r_shift;
   logic [N-1:0]          r_bitmap;
   logic [7:0]            r_count;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_any_high;
   logic                  r_overrun;

   logic                  w_baud_end;
   logic                  w_stop_early;
   logic                  w_last_byte;
   logic [7:0]            w_checksum;
   logic [7:0]            w_byte;
   logic                  w_tx_nxt;
   logic                  w_busy_nxt;

   assign w_baud_end   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
   assign w_stop_early = (r_baud == BAUD_W'(CLKS_PER_BIT - 2));
   assign w_last_byte  = (r_idx == IDX_W'(NFRAME - 1));

   // Checksum covers count and bitmap; both are frozen while a frame is in flight.
   always_comb begin
      w_checksum = r_count;
      for (int k = 0; k < int'(NBYTES); k++) begin
         w_checksum = w_checksum ^ r_bitmap[8*k +: 8];
      end
   end

   always_comb begin
      w_byte = HEADER;
      if (r_idx == IDX_W'(1)) begin
         w_byte = r_count;
      end else if (w_last_byte) begin
         w_byte = w_checksum;
      end else begin
         for (int k = 0; k < int'(NBYTES); k++) begin
            if (r_idx == IDX_W'(k + 2)) begin
               w_byte = r_bitmap[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Non-final stop bits leave one cycle early; the LOAD cycle completes them.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT: begin
            if (sweep_done) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_START;
         end
         S_START: begin
            if (w_baud_end) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_end && (r_bit == 3'd7)) begin
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_last_byte && w_baud_end) begin
               w_state_nxt = S_DONE;
            end else if (!w_last_byte && w_stop_early) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_DONE: begin
            w_state_nxt = S_COLLECT;
         end
         default: begin
            w_state_nxt = S_COLLECT;
         end
      endcase
   end

   // Next value of the registered serial line and busy flag.
   always_comb begin
      w_tx_nxt   = r_tx;
      w_busy_nxt = (w_state_nxt == S_LOAD)  || (w_state_nxt == S_START) ||
                   (w_state_nxt == S_DATA)  || (w_state_nxt == S_STOP);
      case (r_state)
         S_LOAD: begin
            w_tx_nxt = 1'b0;
         end
         S_START: begin
            if (w_baud_end) begin
               w_tx_nxt = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_tx_nxt = (r_bit == 3'd7) ? 1'b1 : r_shift[1];
            end
         end
         default: begin
            w_tx_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
      end else begin
         r_tx   <= w_tx_nxt;
         r_busy <= w_busy_nxt;
      end
   end

   // Baud timing, bit/byte sequencing and the transmit shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_baud  <= '0;
         r_bit   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            S_COLLECT: begin
               r_baud <= '0;
               r_idx  <= '0;
            end
            S_LOAD: begin
               r_shift <= w_byte;
               r_baud  <= '0;
               r_bit   <= '0;
            end
            S_START: begin
               r_baud <= w_baud_end ? '0 : r_baud + BAUD_W'(1);
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= r_bit + 3'd1;
                  r_shift <= {1'b0, r_shift[7:1]};
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (!w_last_byte && w_stop_early) begin
                  r_baud <= '0;
                  r_idx  <= r_idx + IDX_W'(1);
               end else if (w_baud_end) begin
                  r_baud <= '0;
               end else begin
                  r_baud <= r_baud + BAUD_W'(1);
               end
            end
            default: begin
               r_baud <= '0;
               r_idx  <= '0;
            end
         endcase
      end
   end

   // Result collection; a sample coincident with sweep_done is still stored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bitmap   <= '0;
         r_count    <= '0;
         r_any_high <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if ((r_state == S_COLLECT) && sample_valid) begin
            r_bitmap[sample_vec] <= sample_bit;
            r_count              <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
            r_any_high           <= r_any_high | sample_bit;
         end
         if (r_state == S_DONE) begin
            r_bitmap   <= '0;
            r_count    <= '0;
            r_any_high <= 1'b0;
         end
         if (r_busy && (sample_valid || sweep_done)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign tx       = r_tx;
   assign busy     = r_busy;
   assign any_high = r_any_high;
   assign overrun  = r_overrun;

endmodule
